// File: rtl/program_loader_pkg.sv
// Shared constants and helpers for the program loader.
package program_loader_pkg;

    // Loader state encodings
    localparam logic [2:0] LDR_IDLE   = 3'd0;
    localparam logic [2:0] LDR_HEADER = 3'd1;
    localparam logic [2:0] LDR_LOAD   = 3'd2;
    localparam logic [2:0] LDR_FLUSH  = 3'd3;
    localparam logic [2:0] LDR_DONE   = 3'd4;
    localparam logic [2:0] LDR_ERROR  = 3'd5;

    // Bytes per instruction word
    localparam int unsigned LANES = 4;

    typedef enum logic [2:0] {
        StIdle   = LDR_IDLE,
        StHeader = LDR_HEADER,
        StLoad   = LDR_LOAD,
        StFlush  = LDR_FLUSH,
        StDone   = LDR_DONE,
        StError  = LDR_ERROR
    } ldr_state_e;

    // Big-endian assembly: older bytes move toward bit 0 (MSB), new byte lands in [24:31].
    function automatic logic [0:31] shift_in(input logic [0:31] word, input logic [7:0] b);
        return {word[8:31], b};
    endfunction

endpackage

// File: rtl/program_loader_if.sv
// Valid/ready byte stream feeding the program loader.
interface program_loader_if;
    logic       in_valid;
    logic [7:0] in_byte;
    logic       in_ready;

    modport master (output in_valid, output in_byte, input in_ready);
    modport slave  (input in_valid, input in_byte, output in_ready);
endinterface

// File: rtl/program_loader_byte_assembler.sv
// Byte assembler: shifts accepted bytes into a big-endian 32-bit word.
module program_loader_byte_assembler
    import program_loader_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  in_byte,
    output logic [0:31] word,
    output logic        word_valid,
    output logic        last
);

    logic [1:0] lane_q;

    // The byte accepted while last is high completes the word
    assign last = (lane_q == 2'(LANES - 1));

    // Shift register, lane counter and completion pulse
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            lane_q     <= 2'd0;
            word       <= '0;
            word_valid <= 1'b0;
        end else begin
            word_valid <= accept && last;
            if (accept) begin
                word   <= shift_in(word, in_byte);
                lane_q <= lane_q + 2'd1;
            end
        end
    end

endmodule

// File: rtl/program_loader.sv
// Program loader: writes a length-prefixed byte stream into program memory
// and holds the CPU until the whole image is committed.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int unsigned DEPTH = 256
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    program_loader_if.slave    in_if,
    output logic [0:31]        wadr,
    output logic [0:31]        wvalue,
    output logic               wenable,
    output logic               cpu_hold,
    output logic               done,
    output logic               error,
    output logic [31:0]        loaded
);

    ldr_state_e  state_q, state_d;
    logic [31:0] len_q;
    logic [31:0] loaded_q;
    logic [0:31] wadr_q;
    logic        wr_q;

    logic        accept;
    logic        clear;
    logic        word_done;
    logic [0:31] asm_word;
    logic        asm_valid;
    logic        asm_last;
    logic [0:31] hdr_len;

    assign in_if.in_ready = (state_q == StHeader) || (state_q == StLoad);
    assign accept         = in_if.in_valid && in_if.in_ready;
    assign word_done      = accept && asm_last;
    // Length decision is made on the edge that accepts the 4th header byte
    assign hdr_len        = shift_in(asm_word, in_if.in_byte);

    program_loader_byte_assembler u_asm (
        .clock      (clock),
        .reset      (reset),
        .clear      (clear),
        .accept     (accept),
        .in_byte    (in_if.in_byte),
        .word       (asm_word),
        .word_valid (asm_valid),
        .last       (asm_last)
    );

    // Next-state logic; the assembler is held clear whenever no session is streaming
    always_comb begin
        state_d = state_q;
        clear   = 1'b0;
        unique case (state_q)
            StIdle: begin
                clear = 1'b1;
                if (start) state_d = StHeader;
            end
            StHeader: begin
                if (word_done) begin
                    if (hdr_len == 32'd0)             state_d = StDone;
                    else if (hdr_len > 32'(DEPTH))    state_d = StError;
                    else                              state_d = StLoad;
                end
            end
            StLoad: begin
                if (word_done && (loaded_q + 32'd1 == len_q)) state_d = StFlush;
            end
            StFlush: begin
                state_d = StDone;
            end
            StDone, StError: begin
                clear = 1'b1;
                if (start) state_d = StHeader;
            end
            default: state_d = StIdle;
        endcase
    end

    // State, length, index and write-port registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= StIdle;
            len_q    <= '0;
            loaded_q <= '0;
            wadr_q   <= '0;
            wr_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            wr_q    <= (state_q == StLoad) && word_done;
            if ((state_q == StHeader) && word_done) len_q <= hdr_len;
            if ((state_d == StHeader) && (state_q != StHeader)) begin
                loaded_q <= '0;
                wadr_q   <= '0;
            end else if ((state_q == StLoad) && word_done) begin
                wadr_q   <= loaded_q;
                loaded_q <= loaded_q + 32'd1;
            end
        end
    end

    // The assembler word is the completed word during its valid pulse
    assign wenable  = wr_q && asm_valid;
    assign wvalue   = asm_word;
    assign wadr     = wadr_q;
    assign loaded   = loaded_q;
    assign cpu_hold = (state_q == StHeader) || (state_q == StLoad) ||
                      (state_q == StFlush)  || (state_q == StError);
    assign done     = (state_q == StDone);
    assign error    = (state_q == StError);

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: stimulus pushes expected writes,
// a negedge monitor pops and checks each wenable pulse.
module tb_program_loader;
    import program_loader_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [31:0] wadr;
    logic [31:0] wvalue;
    logic        wenable;
    logic        cpu_hold;
    logic        done;
    logic        error;
    logic [31:0] loaded;

    program_loader_if in_if ();

    program_loader #(.DEPTH(256)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .in_if    (in_if),
        .wadr     (wadr),
        .wvalue   (wvalue),
        .wenable  (wenable),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error),
        .loaded   (loaded)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] adr;
        logic [31:0] val;
        int          cyc;
    } wr_t;
    wr_t sb[$];

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every write must match the head of the scoreboard
    always @(negedge clock) begin
        if (wenable === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: adr 0x%08h val 0x%08h, expected none",
                         wadr, wvalue);
            end else begin
                wr_t e;
                e = sb.pop_front();
                check("write_adr", wadr, e.adr);
                check("write_val", wvalue, e.val);
                check("write_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int bound, output bit ok);
        logic r;
        ok = 1'b0;
        in_if.in_valid = 1'b1;
        in_if.in_byte  = b;
        for (int i = 0; i < bound; i++) begin
            r = in_if.in_ready;
            tick();
            if (r) begin
                ok = 1'b1;
                break;
            end
        end
        in_if.in_valid = 1'b0;
    endtask

    // Sends one big-endian word; gap inserts an idle cycle before every byte
    task automatic send32(input logic [31:0] w, input bit gap);
        bit ok;
        logic [31:0] t;
        for (int i = 0; i < 4; i++) begin
            if (gap) tick();
            t = w >> (8 * (3 - i));
            send_byte(t[7:0], 20, ok);
            if (!ok) begin
                errors++;
                checks++;
                $display("FAIL accept_timeout: byte 0x%02h not accepted, expected accept", t[7:0]);
            end
        end
    endtask

    task automatic send_data(input int k, input logic [31:0] w, input bit gap);
        wr_t e;
        send32(w, gap);
        e.adr = 32'(k);
        e.val = w;
        e.cyc = cyc;
        sb.push_back(e);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Checks the release sequence right after the final byte was accepted
    task automatic check_release(input string tag, input logic [31:0] n);
        check({tag, "_flush_hold"}, 32'(cpu_hold), 32'd1);
        tick();
        check({tag, "_done_hold"}, 32'(cpu_hold), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_loaded"}, loaded, n);
    endtask

    initial begin
        bit ok;
        in_if.in_valid = 1'b0;
        in_if.in_byte  = 8'h00;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_in_ready", 32'(in_if.in_ready), 32'd0);
        check("rst_wenable", 32'(wenable), 32'd0);
        check("rst_cpu_hold", 32'(cpu_hold), 32'd0);
        check("rst_done_error", {30'd0, done, error}, 32'd0);
        check("rst_wadr", wadr, 32'd0);
        check("rst_wvalue", wvalue, 32'd0);
        check("rst_loaded", loaded, 32'd0);

        // Two-word image, valid held high
        pulse_start();
        check("t1_hold", 32'(cpu_hold), 32'd1);
        send32(32'd2, 1'b0);
        send_data(0, 32'h12345678, 1'b0);
        send_data(1, 32'h9ABCDEF0, 1'b0);
        check_release("t1", 32'd2);

        // Same image with in_valid toggling
        pulse_start();
        check("t2_done_clear", 32'(done), 32'd0);
        send32(32'd2, 1'b1);
        send_data(0, 32'h12345678, 1'b1);
        send_data(1, 32'h9ABCDEF0, 1'b1);
        check_release("t2", 32'd2);

        // Empty image goes straight to DONE
        pulse_start();
        send32(32'd0, 1'b0);
        check("t3_done", 32'(done), 32'd1);
        check("t3_hold", 32'(cpu_hold), 32'd0);
        check("t3_loaded", loaded, 32'd0);

        // Oversized image (257 > DEPTH)
        pulse_start();
        send32(32'h00000101, 1'b0);
        check("t4_error", 32'(error), 32'd1);
        check("t4_hold", 32'(cpu_hold), 32'd1);
        check("t4_in_ready", 32'(in_if.in_ready), 32'd0);
        send_byte(8'hAA, 5, ok);
        check("t4_no_accept", 32'(ok), 32'd0);
        pulse_start();
        check("t4_error_clear", 32'(error), 32'd0);
        check("t4_restart_ready", 32'(in_if.in_ready), 32'd1);

        // Reset in the middle of a three-word load
        reset = 1'b1;
        tick();
        reset = 1'b0;
        pulse_start();
        send32(32'd3, 1'b0);
        send_data(0, 32'h01020304, 1'b0);
        send_byte(8'h05, 20, ok);
        send_byte(8'h06, 20, ok);
        check("t5_loaded_before", loaded, 32'd1);
        reset = 1'b1;
        tick();
        check("t5_rst_wenable", 32'(wenable), 32'd0);
        check("t5_rst_hold", 32'(cpu_hold), 32'd0);
        check("t5_rst_in_ready", 32'(in_if.in_ready), 32'd0);
        check("t5_rst_loaded", loaded, 32'd0);
        check("t5_rst_wadr", wadr, 32'd0);
        reset = 1'b0;
        tick();
        pulse_start();
        send32(32'd1, 1'b0);
        send_data(0, 32'hCAFEF00D, 1'b0);
        check_release("t5", 32'd1);

        // Restart from DONE with a new one-word image
        pulse_start();
        check("t6_done_clear", 32'(done), 32'd0);
        send32(32'd1, 1'b0);
        send_data(0, 32'hDEADBEEF, 1'b0);
        check_release("t6", 32'd1);

        tick();
        tick();
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/program_loader.md
# program_loader

Writes a program image into program memory from a byte stream. The CPU datapath only reads program memory; this block is the writer side of that interface. It receives a length-prefixed image over a valid/ready byte channel and assembles big-endian 32-bit instruction words. It writes those words at consecutive addresses from 0 and holds the CPU stalled until the image is fully committed.

## Interface
Parameters:
- DEPTH, 256: program memory capacity in words; the largest image accepted.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  begins a load session; sampled only in IDLE, DONE and ERROR.
- in_valid  in  1  byte present on in_byte.
- in_byte  in  8  stream byte.
- in_ready  out  1  loader accepts a byte; a transfer happens on an edge where in_valid && in_ready.
- wadr  out  32  program memory write address in words, bit 0 = MSB.
- wvalue  out  32  instruction word, bit 0 = MSB.
- wenable  out  1  program memory write strobe; one cycle per word.
- cpu_hold  out  1  holds the CPU's program counter and write enables.
- done  out  1  image fully committed.
- error  out  1  header length exceeded DEPTH.
- loaded  out  32  number of words written in the current session.

## Operation
- States: IDLE, HEADER, LOAD, FLUSH, DONE, ERROR.
- IDLE:
  - in_ready=0, cpu_hold=0.
  - start=1 -> HEADER; clear loaded and the byte counter.
- HEADER:
  - in_ready=1, cpu_hold=1.
  - Accept 4 bytes, MSB first: byte 0 -> bits [0:7], byte 3 -> bits [24:31].
  - The assembled value is the length N.
  - On the 4th byte: N==0 -> DONE; N>DEPTH -> ERROR; otherwise -> LOAD.
- LOAD:
  - in_ready=1, cpu_hold=1.
  - Bytes are assembled the same way.
  - On the 4th byte of word k (k from 0), in the next cycle: wenable=1, wadr=k, wvalue=word, and loaded becomes k+1.
  - On the 4th byte of word N-1 -> FLUSH.
- FLUSH:
  - in_ready=0, cpu_hold=1.
  - The final write is presented this cycle.
  - Next state is DONE.
- DONE:
  - done=1, cpu_hold=0, in_ready=0.
  - loaded holds N.
  - start=1 -> HEADER; done clears on entry to HEADER.
- ERROR:
  - error=1, cpu_hold=1, in_ready=0.
  - Program memory is untouched.
  - start=1 -> HEADER with error cleared; reset -> IDLE.
- start is ignored in HEADER, LOAD and FLUSH.
- in_valid without in_ready is not a transfer. The producer holds its byte; the loader holds its state.
- The byte counter is 2 bits and wraps 3->0 on each completed word. The partial word is discarded on reset or on leaving LOAD.
- Width rules:
  - N is compared as an unsigned 32-bit value.
  - The word index is 32 bits; it never exceeds DEPTH-1 because of the header check.

## Timing
- Reset values:
  - State: IDLE.
  - in_ready, wenable, cpu_hold, done, error: 0.
  - wadr, wvalue, loaded: 0.
- Reset mid-load:
  - On the next edge the state returns to IDLE and wenable=0.
  - Words already written stay in memory.
  - cpu_hold drops; the system keeps reset asserted if it does not want the CPU to run.
- Throughput: one byte per cycle. A word needs 4 accepted bytes. wenable pulses 1 cycle after the 4th accepted byte.
- Simultaneous events: in the cycle wenable is high for word k, the first byte of word k+1 can already be accepted. No stall.
- Release latency: cpu_hold falls 2 cycles after the final byte is accepted (FLUSH, then DONE). The final memory write is therefore complete before the CPU fetches.
- All outputs are registered or decoded from the state register only. There is no combinational path from in_valid to in_ready.

## Structure
- Shared constants, added to constants.v:
  - State encodings: LDR_IDLE, LDR_HEADER, LDR_LOAD, LDR_FLUSH, LDR_DONE, LDR_ERROR, 3 bits.
  - Byte-lane count: 4.
- One sub-module, byte_assembler:
  - Contains the 32-bit shift register (shift left 8, insert at [24:31]) and the 2-bit lane counter.
  - Ports: clock, reset, clear, accept, in_byte, word, word_valid.
  - word_valid is a 1-cycle pulse, registered, coincident with the updated word.
  - The top level holds the FSM, the index counter and the write port registers.

## Test plan
- Reset, then start with stream 00 00 00 02, 12 34 56 78, 9A BC DE F0 (valid held high). Required:
  - writes [0]=0x12345678, [1]=0x9ABCDEF0, each one cycle after its 4th byte;
  - loaded=2; done=1;
  - cpu_hold falls 2 cycles after the last byte.
- Same image with in_valid toggled 1,0,1,0. Required: identical writes; no byte lost or duplicated.
- Header 00 00 00 00. Required: DONE right after the header; no wenable pulse; loaded=0.
- DEPTH=256 with header 00 00 01 01 (257). Required:
  - ERROR, error=1, cpu_hold=1, in_ready=0;
  - later bytes not accepted; no write.
- Header 3, then reset after 6 data bytes. Required:
  - word 0 written; word 1 never written;
  - outputs at reset values next cycle;
  - a fresh start then loads correctly from address 0.
- In DONE, pulse start with a new 1-word image 00 00 00 01, DE AD BE EF. Required: done clears; [0]=0xDEADBEEF; done=1 again.
